// File: rtl/tomasulo_pkg.sv
// Shared opcode and class definitions for the Tomasulo issue path.
// Opcodes are compared as 32-bit values so that any TYPE_W up to 32 can be classified.
package tomasulo_pkg;

    localparam logic [31:0] OP_ADD = 32'h01;
    localparam logic [31:0] OP_SUB = 32'h02;
    localparam logic [31:0] OP_MUL = 32'h03;
    localparam logic [31:0] OP_DIV = 32'h04;

    typedef enum logic {
        CLS_AR = 1'b0,
        CLS_MR = 1'b1
    } iq_class_e;

    function automatic logic is_legal(input logic [31:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL) || (op == OP_DIV);
    endfunction

    // Illegal opcodes report CLS_AR; they never issue, so the class is only cosmetic.
    function automatic iq_class_e op_class(input logic [31:0] op);
        return ((op == OP_MUL) || (op == OP_DIV)) ? CLS_MR : CLS_AR;
    endfunction

endpackage

// File: rtl/dual_issue_queue_if.sv
// Decode-side enqueue, reservation-station issue and status signals of the dual-issue queue.
// The queue connects through the slave modport; its environment uses master.
interface dual_issue_queue_if #(
    parameter int DEPTH  = 8,
    parameter int TYPE_W = 8,
    parameter int REG_W  = 8,
    parameter int AR_N   = 3,
    parameter int MR_N   = 2
);
    logic [1:0]                 in_valid;
    logic                       in_ready;
    logic [TYPE_W-1:0]          in0_type, in1_type;
    logic [REG_W-1:0]           in0_dst, in0_src1, in0_src2;
    logic [REG_W-1:0]           in1_dst, in1_src1, in1_src2;
    logic [$clog2(AR_N+1)-1:0]  ar_free;
    logic [$clog2(MR_N+1)-1:0]  mr_free;
    logic                       flush;
    logic [1:0]                 select_instruction;
    logic [TYPE_W-1:0]          out0_type, out1_type;
    logic [REG_W-1:0]           out0_dst, out0_src1, out0_src2;
    logic [REG_W-1:0]           out1_dst, out1_src1, out1_src2;
    logic                       out0_class, out1_class;
    logic [$clog2(DEPTH+1)-1:0] count;
    logic                       err;

    modport master (
        output in_valid, in0_type, in1_type,
        output in0_dst, in0_src1, in0_src2, in1_dst, in1_src1, in1_src2,
        output ar_free, mr_free, flush,
        input  in_ready, select_instruction,
        input  out0_type, out0_dst, out0_src1, out0_src2, out0_class,
        input  out1_type, out1_dst, out1_src1, out1_src2, out1_class,
        input  count, err
    );

    modport slave (
        input  in_valid, in0_type, in1_type,
        input  in0_dst, in0_src1, in0_src2, in1_dst, in1_src1, in1_src2,
        input  ar_free, mr_free, flush,
        output in_ready, select_instruction,
        output out0_type, out0_dst, out0_src1, out0_src2, out0_class,
        output out1_type, out1_dst, out1_src1, out1_src2, out1_class,
        output count, err
    );

endinterface

// File: rtl/iq_entry_ram.sv
// Entry storage for the issue queue: DEPTH words, two write ports, two asynchronous reads.
// The queue never writes both ports to the same address in one cycle.
module iq_entry_ram #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     we0,
    input  logic [$clog2(DEPTH)-1:0] waddr0,
    input  logic [WIDTH-1:0]         wdata0,
    input  logic                     we1,
    input  logic [$clog2(DEPTH)-1:0] waddr1,
    input  logic [WIDTH-1:0]         wdata1,
    input  logic [$clog2(DEPTH)-1:0] raddr0,
    output logic [WIDTH-1:0]         rdata0,
    input  logic [$clog2(DEPTH)-1:0] raddr1,
    output logic [WIDTH-1:0]         rdata1
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: storage has no reset; validity is tracked by head/tail/count, so stale words are never observed.
    always_ff @(posedge clk) begin
        if (we0) mem[waddr0] <= wdata0;
        if (we1) mem[waddr1] <= wdata1;
    end

    assign rdata0 = mem[raddr0];
    assign rdata1 = mem[raddr1];

endmodule

// File: rtl/dual_issue_queue.sv
// In-order two-wide instruction queue feeding the AR/MR reservation stations.
// Issue strobes are combinational from registered queue state and the free-slot counts.
module dual_issue_queue
    import tomasulo_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int TYPE_W = 8,
    parameter int REG_W  = 8,
    parameter int AR_N   = 3,
    parameter int MR_N   = 2
) (
    input logic              clk,
    input logic              rst,
    dual_issue_queue_if.slave q
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int ENT_W = TYPE_W + 3 * REG_W;
    localparam int AR_W  = $clog2(AR_N + 1);
    localparam int MR_W  = $clog2(MR_N + 1);

    logic [PTR_W-1:0] head, tail, head1, tail1;
    logic [CNT_W-1:0] count_q;
    logic             err_q;

    logic [ENT_W-1:0] rd0, rd1, wdata0, wdata1;
    logic [TYPE_W-1:0] t0, t1;
    logic [AR_W-1:0]  ar_free;
    logic [MR_W-1:0]  mr_free;

    logic      has0, has1, legal0, legal1, iss0, iss1, deq0, deq1;
    iq_class_e cls0, cls1;
    int        free0, free1, need1;

    logic       enq, enq2, err_set;
    logic [1:0] enq_n, deq_n;

    assign head1 = head + PTR_W'(1);
    assign tail1 = tail + PTR_W'(1);

    assign wdata0 = {q.in0_type, q.in0_dst, q.in0_src1, q.in0_src2};
    assign wdata1 = {q.in1_type, q.in1_dst, q.in1_src1, q.in1_src2};

    iq_entry_ram #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_ram (
        .clk    (clk),
        .we0    (enq),
        .waddr0 (tail),
        .wdata0 (wdata0),
        .we1    (enq2),
        .waddr1 (tail1),
        .wdata1 (wdata1),
        .raddr0 (head),
        .rdata0 (rd0),
        .raddr1 (head1),
        .rdata1 (rd1)
    );

    assign t0      = rd0[ENT_W-1 -: TYPE_W];
    assign t1      = rd1[ENT_W-1 -: TYPE_W];
    assign ar_free = q.ar_free;
    assign mr_free = q.mr_free;

    // NOTE: every signal below is assigned on every pass with no branches, so nothing can hold a stale value.
    always_comb begin
        has0   = (count_q != '0);
        has1   = (count_q >= CNT_W'(2));
        legal0 = is_legal(32'(t0));
        legal1 = is_legal(32'(t1));
        cls0   = op_class(32'(t0));
        cls1   = op_class(32'(t1));
        free0  = (cls0 == CLS_MR) ? int'(mr_free) : int'(ar_free);
        free1  = (cls1 == CLS_MR) ? int'(mr_free) : int'(ar_free);
        iss0   = has0 && legal0 && (free0 >= 1);
        deq0   = has0 && (!legal0 || (free0 >= 1));
        // Lane 1 needs a second slot only when lane 0 already took one of the same class.
        need1  = (iss0 && (cls1 == cls0)) ? 2 : 1;
        iss1   = has1 && deq0 && legal1 && (free1 >= need1);
        deq1   = has1 && deq0 && (!legal1 || (free1 >= need1));
    end

    assign q.in_ready = (count_q <= CNT_W'(DEPTH - 2));
    assign enq        = q.in_ready && q.in_valid[0] && !q.flush;
    assign enq2       = enq && q.in_valid[1];
    assign enq_n      = {1'b0, enq} + {1'b0, enq2};
    assign deq_n      = {1'b0, deq0} + {1'b0, deq1};
    assign err_set    = !q.flush && ((deq0 && !legal0) || (deq1 && !legal1));

    // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else if (q.flush) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else begin
            head    <= head + PTR_W'(deq_n);
            tail    <= tail + PTR_W'(enq_n);
            count_q <= count_q + CNT_W'(enq_n) - CNT_W'(deq_n);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)          err_q <= 1'b0;
        else if (err_set) err_q <= 1'b1;
    end

    assign q.select_instruction = q.flush ? 2'b00 : {iss1, iss0};

    assign q.out0_type  = has0 ? t0 : '0;
    assign q.out0_dst   = has0 ? rd0[3*REG_W-1 -: REG_W] : '0;
    assign q.out0_src1  = has0 ? rd0[2*REG_W-1 -: REG_W] : '0;
    assign q.out0_src2  = has0 ? rd0[REG_W-1:0] : '0;
    assign q.out0_class = has0 && (cls0 == CLS_MR);

    assign q.out1_type  = has1 ? t1 : '0;
    assign q.out1_dst   = has1 ? rd1[3*REG_W-1 -: REG_W] : '0;
    assign q.out1_src1  = has1 ? rd1[2*REG_W-1 -: REG_W] : '0;
    assign q.out1_src2  = has1 ? rd1[REG_W-1:0] : '0;
    assign q.out1_class = has1 && (cls1 == CLS_MR);

    assign q.count = count_q;
    assign q.err   = err_q;

endmodule
